// File: rtl/audio_mem_pkg.sv
// Shared constants and grant encoding for the audio sample ring controller.
package audio_mem_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 262144;

  // One-hot so the arbiter result doubles as the pair of grant strobes.
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_WR   = 2'b01,
    GNT_RD   = 2'b10
  } grant_e;

endpackage

// File: rtl/audio_mem_ring_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter for the single memory port.
// The grant is combinational; only the last winner is remembered.
module rr_arb2
  import audio_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_wr,
  input  logic   req_rd,
  output grant_e gnt
);

  grant_e last_grant;

  // Lone requester always wins; under contention the side that lost last time wins.
  always_comb begin
    gnt = GNT_NONE;
    if (req_wr && req_rd) begin
      gnt = (last_grant == GNT_RD) ? GNT_WR : GNT_RD;
    end else if (req_wr) begin
      gnt = GNT_WR;
    end else if (req_rd) begin
      gnt = GNT_RD;
    end
  end

  // Remember the most recent winner; starting at RD hands the first contention to the writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_RD;
    end else if (gnt != GNT_NONE) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/audio_mem_ring_ctrl.sv
// Sample ring buffer over a single-port memory: the record path pushes,
// the playback path pops, one memory access per cycle.
module audio_mem_ring_ctrl
  import audio_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              clear,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              underrun,
  output logic              overrun,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  output logic [1:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_elig;
  logic              rd_elig;
  grant_e            gnt;
  logic [RD_LAT-1:0] rd_vld_p;
  logic [DATA_W-1:0] rd_hold;

  // Ring pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_ONE;
  endfunction

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Clear suppresses both requesters so nothing is committed in the flush cycle.
  assign wr_elig = wr_valid & ~full  & ~clear;
  assign rd_elig = rd_req   & ~empty & ~clear;

  rr_arb2 u_arb (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .req_wr (wr_elig),
    .req_rd (rd_elig),
    .gnt    (gnt)
  );

  assign wr_ready = (gnt == GNT_WR);
  assign rd_gnt   = (gnt == GNT_RD);

  assign mem_chipselect = wr_ready | rd_gnt;
  assign mem_write      = wr_ready;
  assign mem_address    = wr_ready ? wr_ptr : rd_ptr;
  assign mem_writedata  = wr_data;
  assign mem_clken      = 1'b1;
  assign mem_byteenable = 2'b11;

  // Pointers and fill level; at most one of the two grants is high per cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ready) wr_ptr <= next_addr(wr_ptr);
      if (rd_gnt)   rd_ptr <= next_addr(rd_ptr);
      if (wr_ready) begin
        count <= count + CNT_ONE;
      end else if (rd_gnt) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Sticky error flags: a request that hit an empty or full ring.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else if (clear) begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      underrun <= underrun | (rd_req & empty);
      overrun  <= overrun  | (wr_valid & full);
    end
  end

  // Read-valid pipeline matches the memory latency; clear leaves in-flight reads alone.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_vld_p <= '0;
    end else begin
      rd_vld_p <= RD_LAT'({rd_vld_p, rd_gnt});
    end
  end

  assign rd_valid = rd_vld_p[RD_LAT-1];

  // Capture the returned word so rd_data stays stable between deliveries.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_hold <= '0;
    end else if (rd_valid) begin
      rd_hold <= mem_readdata;
    end
  end

  assign rd_data = rd_valid ? mem_readdata : rd_hold;

endmodule

// File: doc/audio_mem_ring_ctrl.md
# audio_mem_ring_ctrl

Ring-buffer controller that turns the 256K x 16 on-chip memory in the codec system into a single sample FIFO shared by two requesters: the WM8731 record path, which pushes ADC samples, and the playback path, which pops samples for the DAC. The block owns the write and read pointers, arbitrates the single memory port cycle by cycle, and reports the fill level. It sits between the I2S serializers and the memory slave port, in the 12 MHz codec clock domain.

## Interface
- ADDR_W, 18, memory word-address width
- DATA_W, 16, sample/word width
- DEPTH, 262144, ring capacity in words (1..2^ADDR_W, need not be a power of 2)
- RD_LAT, 1, memory read latency in cycles (1 or 2)

- clk_clk  in  1  codec-domain clock
- reset_reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of ring state
- wr_valid  in  1  record sample offered
- wr_data  in  DATA_W  record sample
- wr_ready  out  1  write accepted this cycle
- rd_req  in  1  playback sample requested
- rd_gnt  out  1  read accepted this cycle
- rd_valid  out  1  read data valid
- rd_data  out  DATA_W  read sample
- count  out  ADDR_W+1  words stored
- full, empty  out  1 each  count==DEPTH, count==0
- underrun  out  1  sticky: rd_req while empty
- overrun  out  1  sticky: wr_valid while full
- mem_address  out  ADDR_W  memory address
- mem_chipselect, mem_write  out  1 each  memory command
- mem_clken  out  1  constant 1
- mem_byteenable  out  2  constant 2'b11
- mem_writedata  out  DATA_W  write data
- mem_readdata  in  DATA_W  read data

## Operation
- Eligibility: write eligible = wr_valid & !full & !clear; read eligible = rd_req & !empty & !clear.
- Arbitration (one memory access per cycle): if only one requester is eligible, that requester is granted. If both are eligible, round-robin on last_grant: the requester not granted most recently wins. After reset, last_grant = RD, so the first contended cycle goes to the write.
- Grant outputs: wr_ready = write grant; rd_gnt = read grant. Both are combinational in the same cycle. A transfer occurs when the request and the grant are high together.
- Memory command:
  - On a write grant: mem_chipselect=1, mem_write=1, mem_address=wr_ptr, mem_writedata=wr_data.
  - On a read grant: mem_chipselect=1, mem_write=0, mem_address=rd_ptr.
  - With no grant: mem_chipselect=0, mem_write=0, mem_address=rd_ptr.
- Pointers: wr_ptr advances on a write grant, rd_ptr on a read grant. Each goes DEPTH-1 -> 0.
- count: +1 on a write grant, -1 on a read grant. The two never occur in the same cycle.
- clear:
  - Next edge: wr_ptr, rd_ptr, count -> 0; underrun, overrun -> 0.
  - No grants are issued in the clear cycle.
  - An in-flight read still delivers rd_valid.
- Sticky flags: underrun sets on rd_req & empty; overrun sets on wr_valid & full. Each clears only on reset or clear.
- Reset values: all pointers, count, rd_valid, rd_data, underrun, overrun = 0; empty = 1; full = 0; last_grant = RD; mem command outputs idle.

## Timing
- Write: zero added latency; the sample is committed at the grant edge.
- Read: rd_valid pulses exactly RD_LAT cycles after the rd_gnt cycle. rd_data is registered from mem_readdata and held until the next rd_valid.
- Read pipeline: a RD_LAT-deep valid shift register. Back-to-back read grants yield back-to-back rd_valid.
- Flags: full, empty and count update on the edge after the grant. A read of a word written in cycle N may be granted in cycle N+1.
- Bandwidth: at 48 kHz stereo per direction, utilisation is under 2%. Starvation is bounded to 1 cycle under contention.
- Reset mid-operation: asynchronous; in-flight reads are discarded and rd_valid is forced to 0 immediately.

## Structure
- Package audio_mem_pkg holds:
  - ADDR_W, DATA_W, DEPTH default constants
  - grant enum: GNT_NONE, GNT_WR, GNT_RD
- Sub-module rr_arb2: 2-requester round-robin arbiter holding last_grant, one-hot grant output.
- The top level holds pointers, count, flags, the read-valid pipeline and the memory mux.

## Test plan
- Reset, then write 0x1111, 0x2222, 0x3333 uncontended -> mem_address 0,1,2 with mem_write=1; count=3; empty=0.
- Read 3 times (RD_LAT=1) -> rd_valid one cycle after each rd_gnt; rd_data 0x1111, 0x2222, 0x3333; empty=1.
- Hold wr_valid and rd_req high with count=5 -> grants alternate W,R,W,R starting with W; count oscillates 6,5,6,5.
- DEPTH=4: write 4 words -> full=1, wr_ready=0, overrun=1 on the 5th offer. Read 1, write 1 -> write lands at address 0 (wrap); count=4.
- rd_req while empty -> rd_gnt=0, underrun=1. Next, assert clear with a read in flight -> rd_valid still arrives; count=0; flags=0.
- Assert reset_reset_n low mid-burst -> all outputs return to their reset values asynchronously; the first post-reset write goes to address 0.
